// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory fetch unit.
package imem_pkg;

  localparam int ERR_W        = 2;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  // Widest legal instruction word; narrower builds take the low slice.
  localparam logic [63:0] NOP_WORD = '0;

  function automatic int offset_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Two-entry in-order response buffer with a registered not-full flag.
module imem_resp_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         not_full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         do_push;
  logic         do_pop;

  assign out_valid = (count != 2'd0);
  assign do_pop    = out_valid && out_ready;
  assign do_push   = push && not_full;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      not_full <= 1'b0;
    end else begin
      count    <= count_next;
      not_full <= (count_next != 2'd2);
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: storage is not reset; out_data is gated by out_valid, so stale entries never leak.
  always_ff @(posedge clock) begin
    if (do_push) entry[wr_ptr] <= push_data;
  end

  assign out_data = out_valid ? entry[rd_ptr] : '0;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: word-indexed memory read into a 2-entry response buffer.
// Optional program-load write port enabled by defining IMEM_LOAD_PORT_EN.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_inst,
  output logic [ADDR_W-1:0]        resp_pc,
  output logic [ERR_W-1:0]         resp_err
`ifdef IMEM_LOAD_PORT_EN
  ,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data
`endif
);

  localparam int OFF_W = offset_width(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PAY_W = DATA_W + ADDR_W + ERR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] word_idx;
  logic [ERR_W-1:0]  req_err;
  logic [DATA_W-1:0] read_word;
  logic              accept;
  logic [PAY_W-1:0]  push_data;
  logic [PAY_W-1:0]  out_data;

  // The full shifted PC is range-checked, so high PC bits never alias into the array.
  assign word_idx = req_pc >> OFF_W;

  always_comb begin
    req_err               = '0;
    req_err[ERR_MISALIGN] = |req_pc[OFF_W-1:0];
    req_err[ERR_RANGE]    = (word_idx >= ADDR_W'(DEPTH));
    read_word = (req_err != '0) ? NOP_WORD[DATA_W-1:0] : mem[word_idx[IDX_W-1:0]];
  end

`ifdef IMEM_LOAD_PORT_EN
  // A same-edge fetch captures the pre-write word: the read lands in the buffer on this edge.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_idx] <= load_data;
  end
`endif

  assign accept    = req_valid && req_ready;
  assign push_data = {read_word, req_pc, req_err};

  // The read word is registered straight into the buffer, giving one-cycle fetch latency.
  imem_resp_fifo #(
    .W (PAY_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (push_data),
    .not_full  (req_ready),
    .out_valid (resp_valid),
    .out_ready (resp_ready),
    .out_data  (out_data)
  );

  assign {resp_inst, resp_pc, resp_err} = out_data;

endmodule
